// File: rtl/id_pkg.sv
// Shared decode types and RV32I opcode constants for the ID unit.
// Width defaults come from IMM_WIDTH / ARCH_REG_NUM_WIDTH; ID_ILLEGAL_CHECK_EN adds the illegal flag.
`ifndef IMM_WIDTH
`define IMM_WIDTH 21
`endif
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif

package id_pkg;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Instruction-derived fields only; PC and immediate are parameter-sized and stored alongside.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        imm_fmt_t   fmt;
        logic       shift12;
`ifdef ID_ILLEGAL_CHECK_EN
        logic       illegal;
`endif
    } dec_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/id_decode_buffer_if.sv
// Fetch-side and rename-side handshake bundle of the decode buffer.
// out_illegal exists only when ID_ILLEGAL_CHECK_EN is defined.
interface id_decode_buffer_if
    import id_pkg::*;
#(
    parameter int IMM_WIDTH          = `IMM_WIDTH,
    parameter int ARCH_REG_NUM_WIDTH = `ARCH_REG_NUM_WIDTH,
    parameter int PC_WIDTH           = 32
) ();
    logic                          in_valid;
    logic                          in_ready;
    logic [31:0]                   in_instr;
    logic [PC_WIDTH-1:0]           in_pc;
    logic                          out_valid;
    logic                          out_ready;
    logic [PC_WIDTH-1:0]           out_pc;
    logic [6:0]                    out_opcode;
    logic [2:0]                    out_funct3;
    logic [6:0]                    out_funct7;
    logic [ARCH_REG_NUM_WIDTH-1:0] out_rd;
    logic [ARCH_REG_NUM_WIDTH-1:0] out_rs1;
    logic [ARCH_REG_NUM_WIDTH-1:0] out_rs2;
    logic [IMM_WIDTH-1:0]          out_imm;
    imm_fmt_t                      out_imm_fmt;
    logic                          out_imm_shift12;
`ifdef ID_ILLEGAL_CHECK_EN
    logic                          out_illegal;
`endif

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_imm, out_imm_fmt, out_imm_shift12
`ifdef ID_ILLEGAL_CHECK_EN
        , input out_illegal
`endif
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_imm, out_imm_fmt, out_imm_shift12
`ifdef ID_ILLEGAL_CHECK_EN
        , output out_illegal
`endif
    );
endinterface

// File: rtl/id_decode_buffer_imm_field_extractor.sv
// Combinational raw-immediate extraction and format classification of an RV32I word.
// The illegal output is built only when ID_ILLEGAL_CHECK_EN is defined.
module imm_field_extractor
    import id_pkg::*;
#(
    parameter int IMM_WIDTH = `IMM_WIDTH
) (
    input  logic [31:0]          instr,
    output logic [IMM_WIDTH-1:0] imm,
    output imm_fmt_t             fmt,
    output logic                 shift12
`ifdef ID_ILLEGAL_CHECK_EN
    , output logic               illegal
`endif
);
    logic signed [31:0] imm32;

    always_comb begin
        imm32   = '0;
        fmt     = IMM_R;
        shift12 = 1'b0;
`ifdef ID_ILLEGAL_CHECK_EN
        illegal = 1'b0;
`endif
        case (instr[6:0])
            OPC_OP: fmt = IMM_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                imm32 = {{20{instr[31]}}, instr[31:20]};
                fmt   = IMM_I;
            end
            OPC_STORE: begin
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt   = IMM_S;
            end
            OPC_BRANCH: begin
                imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                fmt   = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32   = {{12{instr[31]}}, instr[31:12]};
                fmt     = IMM_U;
                shift12 = 1'b1;
            end
            OPC_JAL: begin
                imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                fmt   = IMM_J;
            end
            default: begin
`ifdef ID_ILLEGAL_CHECK_EN
                illegal = 1'b1;
`endif
            end
        endcase
        // Signed cast sign-extends when IMM_WIDTH exceeds 32 and truncates otherwise.
        imm = IMM_WIDTH'(imm32);
    end
endmodule

// File: rtl/id_decode_buffer.sv
// Decode front half: field split plus a 2-entry registered skid buffer toward rename.
// ID_ILLEGAL_CHECK_EN enables the out_illegal flag for unsupported opcodes.
module id_decode_buffer
    import id_pkg::*;
#(
    parameter int IMM_WIDTH          = `IMM_WIDTH,
    parameter int ARCH_REG_NUM_WIDTH = `ARCH_REG_NUM_WIDTH,
    parameter int PC_WIDTH           = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    id_decode_buffer_if.slave  bus
);
    if (IMM_WIDTH < 21) begin : g_imm_width_check
        $error("id_decode_buffer: IMM_WIDTH must be >= 21");
    end

    dec_entry_t           new_e;
    logic [IMM_WIDTH-1:0] new_imm;
    imm_fmt_t             new_fmt;
    logic                 new_shift12;
`ifdef ID_ILLEGAL_CHECK_EN
    logic                 new_illegal;
`endif

    imm_field_extractor #(.IMM_WIDTH(IMM_WIDTH)) u_imm (
        .instr   (bus.in_instr),
        .imm     (new_imm),
        .fmt     (new_fmt),
        .shift12 (new_shift12)
`ifdef ID_ILLEGAL_CHECK_EN
        , .illegal (new_illegal)
`endif
    );

    always_comb begin
        new_e         = '0;
        new_e.opcode  = bus.in_instr[6:0];
        new_e.rd      = bus.in_instr[11:7];
        new_e.funct3  = bus.in_instr[14:12];
        new_e.rs1     = bus.in_instr[19:15];
        new_e.rs2     = bus.in_instr[24:20];
        new_e.funct7  = bus.in_instr[31:25];
        new_e.fmt     = new_fmt;
        new_e.shift12 = new_shift12;
`ifdef ID_ILLEGAL_CHECK_EN
        new_e.illegal = new_illegal;
`endif
    end

    buf_state_t           state;
    logic                 in_ready_q;
    logic                 out_valid_q;
    dec_entry_t           head_e, skid_e;
    logic [PC_WIDTH-1:0]  head_pc, skid_pc;
    logic [IMM_WIDTH-1:0] head_imm, skid_imm;

    logic push, pop;
    assign push = bus.in_valid & in_ready_q;
    assign pop  = out_valid_q & bus.out_ready;

    // in_ready/out_valid are registered alongside the state so out_ready never reaches in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_e      <= '0;
            head_pc     <= '0;
            head_imm    <= '0;
            skid_e      <= '0;
            skid_pc     <= '0;
            skid_imm    <= '0;
        end else if (flush) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    head_e      <= new_e;
                    head_pc     <= bus.in_pc;
                    head_imm    <= new_imm;
                    state       <= ONE;
                    out_valid_q <= 1'b1;
                end
                ONE: begin
                    if (push && pop) begin
                        head_e   <= new_e;
                        head_pc  <= bus.in_pc;
                        head_imm <= new_imm;
                    end else if (push) begin
                        skid_e     <= new_e;
                        skid_pc    <= bus.in_pc;
                        skid_imm   <= new_imm;
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: if (pop) begin
                    head_e     <= skid_e;
                    head_pc    <= skid_pc;
                    head_imm   <= skid_imm;
                    state      <= ONE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_pc          = head_pc;
    assign bus.out_opcode      = head_e.opcode;
    assign bus.out_funct3      = head_e.funct3;
    assign bus.out_funct7      = head_e.funct7;
    assign bus.out_rd          = ARCH_REG_NUM_WIDTH'(head_e.rd);
    assign bus.out_rs1         = ARCH_REG_NUM_WIDTH'(head_e.rs1);
    assign bus.out_rs2         = ARCH_REG_NUM_WIDTH'(head_e.rs2);
    assign bus.out_imm         = head_imm;
    assign bus.out_imm_fmt     = head_e.fmt;
    assign bus.out_imm_shift12 = head_e.shift12;
`ifdef ID_ILLEGAL_CHECK_EN
    assign bus.out_illegal     = head_e.illegal;
`endif
endmodule
